// File: rtl/r22sdf_pkg.sv
// Shared helpers for the radix-2^2 SDF FFT core, its companions and their benches.
package r22sdf_pkg;

   // Ceiling log2; returns 0 for values of 1 or less.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 32'sd0;
      v = value - 32'sd1;
      while (v > 32'sd0) begin
         result = result + 32'sd1;
         v = v >>> 1;
      end
      return result;
   endfunction

   // Reverse the low 'width' bits of 'value'; bits at and above 'width' are returned as 0.
   function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
      logic [31:0] result;
      result = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) begin
            result[i] = value[width - 1 - i];
         end else begin
            result[i] = 1'b0;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/r22sdf_reorder_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// No reset on the storage or read register so it maps onto block RAM.
module r22sdf_reorder_ram #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem_r [0:(2**AW)-1];

   // Write port: store the incoming sample at its (bit-reversed) location.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // Read port: one-cycle registered read, address supplied every cycle.
   always_ff @(posedge clk) begin
      rd_data <= mem_r[rd_addr];
   end

endmodule

// File: rtl/r22sdf_bitrev_reorder.sv
// Reorders the FFT core's bit-reversed output stream into natural bin order
// using a two-bank (ping-pong) frame buffer. Data passes through bit-exact.
module r22sdf_bitrev_reorder
   import r22sdf_pkg::*;
#(
   parameter int data_resolution = 16,
   parameter int fft_length      = 16,
   localparam int AW             = clog2(fft_length)
) (
   input  logic                       sys_clk,
   input  logic                       sys_rst,
   input  logic                       din_valid,
   input  logic                       din_sof,
   input  logic [data_resolution-1:0] din_r,
   input  logic [data_resolution-1:0] din_i,
   output logic                       dout_valid,
   output logic                       dout_sof,
   output logic [AW-1:0]              dout_idx,
   output logic [data_resolution-1:0] dout_r,
   output logic [data_resolution-1:0] dout_i,
   output logic                       frame_err
);

   localparam int DW = 2 * data_resolution;
   localparam logic [AW-1:0] last_idx = AW'(fft_length - 1);

   // write side state
   logic [AW-1:0] wr_cnt_r;
   logic          wr_bank_r;
   logic          wr_synced_r;

   // read side state
   logic          rd_active_r;
   logic [AW-1:0] rd_cnt_r;
   logic          rd_bank_r;

   // alignment stage between RAM read and output registers
   logic          s1_valid_r;
   logic [AW-1:0] s1_idx_r;

   // combinational write-side decode
   logic          accept_s;
   logic [AW-1:0] cnt_eff_s;
   logic          restart_err_s;
   logic          frame_done_s;
   logic [AW:0]   wr_addr_s;
   logic [AW:0]   rd_addr_s;
   logic [DW-1:0] rd_data_s;

   // Decode the accepted sample: its effective frame position, write address,
   // restart error and whether it completes the frame.
   always_comb begin
      accept_s = din_valid & (wr_synced_r | din_sof);
      if (din_sof) begin
         cnt_eff_s = {AW{1'b0}};
      end else begin
         cnt_eff_s = wr_cnt_r;
      end
      restart_err_s = accept_s & din_sof & wr_synced_r & (wr_cnt_r != {AW{1'b0}});
      frame_done_s  = accept_s & (cnt_eff_s == last_idx);
      wr_addr_s     = {wr_bank_r, AW'(bitrev(32'(cnt_eff_s), AW))};
      rd_addr_s     = {rd_bank_r, rd_cnt_r};
   end

   // Write counter, bank ping-pong, sync tracking and the restart error pulse.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_cnt_r    <= {AW{1'b0}};
         wr_bank_r   <= 1'b0;
         wr_synced_r <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_err <= restart_err_s;
         if (accept_s) begin
            wr_synced_r <= 1'b1;
            wr_cnt_r    <= cnt_eff_s + AW'(1);
            if (frame_done_s) begin
               wr_bank_r <= ~wr_bank_r;
            end else begin
               wr_bank_r <= wr_bank_r;
            end
         end else begin
            wr_synced_r <= wr_synced_r;
            wr_cnt_r    <= wr_cnt_r;
            wr_bank_r   <= wr_bank_r;
         end
      end
   end

   // Read sequencer: a completed frame starts a gapless natural-order sweep of
   // its bank; a completion on the last read simply chains into the next sweep.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         rd_active_r <= 1'b0;
         rd_cnt_r    <= {AW{1'b0}};
         rd_bank_r   <= 1'b0;
      end else if (frame_done_s) begin
         rd_active_r <= 1'b1;
         rd_cnt_r    <= {AW{1'b0}};
         rd_bank_r   <= wr_bank_r;
      end else if (rd_active_r) begin
         if (rd_cnt_r == last_idx) begin
            rd_active_r <= 1'b0;
            rd_cnt_r    <= {AW{1'b0}};
         end else begin
            rd_active_r <= 1'b1;
            rd_cnt_r    <= rd_cnt_r + AW'(1);
         end
      end else begin
         rd_active_r <= 1'b0;
         rd_cnt_r    <= rd_cnt_r;
      end
   end

   // Carry valid and index alongside the registered RAM read.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         s1_valid_r <= 1'b0;
         s1_idx_r   <= {AW{1'b0}};
      end else begin
         s1_valid_r <= rd_active_r;
         s1_idx_r   <= rd_cnt_r;
      end
   end

   // Output registers; data and index hold their last value between bursts.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         dout_valid <= 1'b0;
         dout_sof   <= 1'b0;
         dout_idx   <= {AW{1'b0}};
         dout_r     <= {data_resolution{1'b0}};
         dout_i     <= {data_resolution{1'b0}};
      end else begin
         dout_valid <= s1_valid_r;
         dout_sof   <= s1_valid_r & (s1_idx_r == {AW{1'b0}});
         if (s1_valid_r) begin
            dout_idx <= s1_idx_r;
            dout_r   <= rd_data_s[DW-1:data_resolution];
            dout_i   <= rd_data_s[data_resolution-1:0];
         end else begin
            dout_idx <= dout_idx;
            dout_r   <= dout_r;
            dout_i   <= dout_i;
         end
      end
   end

   r22sdf_reorder_ram #(
      .AW (AW + 1),
      .DW (DW)
   ) u_ram (
      .clk     (sys_clk),
      .wr_en   (accept_s),
      .wr_addr (wr_addr_s),
      .wr_data ({din_r, din_i}),
      .rd_addr (rd_addr_s),
      .rd_data (rd_data_s)
   );

endmodule

// File: tb/tb_r22sdf_bitrev_reorder.sv
// Scoreboard bench for the bit-reversed to natural-order reorder buffer (N=16).
module tb_r22sdf_bitrev_reorder;

   localparam int N  = 16;
   localparam int DR = 16;

   typedef struct {
      int         idx;
      logic [15:0] r;
      logic [15:0] i;
   } exp_t;

   logic          sys_clk = 1'b0;
   logic          sys_rst = 1'b0;
   logic          din_valid = 1'b0;
   logic          din_sof = 1'b0;
   logic [DR-1:0] din_r = '0;
   logic [DR-1:0] din_i = '0;
   logic          dout_valid;
   logic          dout_sof;
   logic [3:0]    dout_idx;
   logic [DR-1:0] dout_r;
   logic [DR-1:0] dout_i;
   logic          frame_err;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   exp_t        exp_q[$];
   int          runs[$];
   logic [15:0] cap_r[$];
   int          run_len    = 0;
   int          sof_cyc    = -1;
   int          err_cycles = 0;
   int          err_cyc    = -1;
   int          last_acc_cyc  = 0;
   int          first_acc_cyc = 0;

   r22sdf_bitrev_reorder #(
      .data_resolution (DR),
      .fft_length      (N)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .din_valid  (din_valid),
      .din_sof    (din_sof),
      .din_r      (din_r),
      .din_i      (din_i),
      .dout_valid (dout_valid),
      .dout_sof   (dout_sof),
      .dout_idx   (dout_idx),
      .dout_r     (dout_r),
      .dout_i     (dout_i),
      .frame_err  (frame_err)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic int tb_bitrev(input int v);
      int r;
      r = 0;
      for (int b = 0; b < 4; b++) r = r | (((v >> b) & 1) << (3 - b));
      return r;
   endfunction

   // Output monitor: scoreboard pop/compare plus burst and error bookkeeping.
   always @(negedge sys_clk) begin
      if (dout_valid === 1'b1) begin
         run_len = run_len + 1;
         if (dout_sof === 1'b1) sof_cyc = cyc;
         cap_r.push_back(dout_r);
         compared = compared + 1;
         if (exp_q.size() == 0) begin
            mismatched = mismatched + 1;
            $display("FAIL unexpected_output: got idx=%0d r=%h, required no output", dout_idx, dout_r);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if ({dout_idx, dout_r, dout_i, dout_sof} !== {4'(e.idx), e.r, e.i, (e.idx == 0)}) begin
               mismatched = mismatched + 1;
               $display("FAIL scoreboard: got idx=%0d r=%h i=%h sof=%b, required idx=%0d r=%h i=%h sof=%b",
                        dout_idx, dout_r, dout_i, dout_sof, e.idx, e.r, e.i, (e.idx == 0));
            end
         end
      end else if (run_len > 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
      if (frame_err === 1'b1) begin
         err_cycles = err_cycles + 1;
         err_cyc = cyc;
      end
   end

   task automatic clear_stats();
      runs.delete();
      cap_r.delete();
      sof_cyc = -1;
      err_cycles = 0;
      err_cyc = -1;
   endtask

   task automatic drive(input logic v, input logic sof, input logic [15:0] r, input logic [15:0] i);
      din_valid = v;
      din_sof   = sof;
      din_r     = r;
      din_i     = i;
      @(posedge sys_clk);
      #1;
      din_valid = 1'b0;
      din_sof   = 1'b0;
   endtask

   // Drive one full frame (sof on k=0); gaps inserts an idle cycle after each sample.
   task automatic send_frame(input int base, input bit gaps);
      logic [15:0] sr[N];
      logic [15:0] si[N];
      for (int k = 0; k < N; k++) begin
         sr[k] = 16'(base + k);
         si[k] = 16'(0 - (base + k));
         drive(1'b1, (k == 0), sr[k], si[k]);
         if (k == 0) first_acc_cyc = cyc;
         last_acc_cyc = cyc;
         if (gaps && k != N - 1) drive(1'b0, 1'b0, 16'($urandom), 16'($urandom));
      end
      for (int j = 0; j < N; j++) begin
         exp_t e;
         e.idx = j;
         e.r = sr[tb_bitrev(j)];
         e.i = si[tb_bitrev(j)];
         exp_q.push_back(e);
      end
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      repeat (3) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge sys_clk);
      compared = compared + 1;
      if ({dout_valid, dout_sof, frame_err} !== 3'b000) begin
         mismatched = mismatched + 1;
         $display("FAIL reset_flags: got valid/sof/err=%b%b%b, required 000", dout_valid, dout_sof, frame_err);
      end
      compared = compared + 1;
      if ({dout_idx, dout_r, dout_i} !== 36'd0) begin
         mismatched = mismatched + 1;
         $display("FAIL reset_data: got idx=%0d r=%h i=%h, required 0", dout_idx, dout_r, dout_i);
      end
      clear_stats();
   endtask

   task automatic test_single_frame();
      logic [15:0] ref_r[N] = '{16'd0, 16'd8, 16'd4, 16'd12, 16'd2, 16'd10, 16'd6, 16'd14,
                               16'd1, 16'd9, 16'd5, 16'd13, 16'd3, 16'd11, 16'd7, 16'd15};
      clear_stats();
      send_frame(0, 1'b0);
      repeat (24) @(negedge sys_clk);
      compared = compared + 1;
      if (sof_cyc !== last_acc_cyc + 2) begin
         mismatched = mismatched + 1;
         $display("FAIL single_latency: got first output cycle %0d, required %0d", sof_cyc, last_acc_cyc + 2);
      end
      compared = compared + 1;
      if (runs.size() != 1 || runs[0] != N) begin
         mismatched = mismatched + 1;
         $display("FAIL single_burst: got %0d bursts (first %0d), required 1 of %0d", runs.size(),
                  (runs.size() > 0) ? runs[0] : 0, N);
      end
      for (int j = 0; j < N; j++) begin
         compared = compared + 1;
         if (j >= cap_r.size() || cap_r[j] !== ref_r[j]) begin
            mismatched = mismatched + 1;
            $display("FAIL single_order[%0d]: got %h, required %h", j,
                     (j < cap_r.size()) ? cap_r[j] : 16'hxxxx, ref_r[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      clear_stats();
      send_frame(16, 1'b0);
      send_frame(32, 1'b0);
      send_frame(48, 1'b0);
      repeat (24) @(negedge sys_clk);
      compared = compared + 1;
      if (runs.size() != 1 || runs[0] != 3 * N) begin
         mismatched = mismatched + 1;
         $display("FAIL b2b_burst: got %0d bursts (first %0d), required 1 of %0d", runs.size(),
                  (runs.size() > 0) ? runs[0] : 0, 3 * N);
      end
   endtask

   task automatic test_gaps();
      clear_stats();
      send_frame(100, 1'b1);
      repeat (24) @(negedge sys_clk);
      compared = compared + 1;
      if (sof_cyc !== last_acc_cyc + 2) begin
         mismatched = mismatched + 1;
         $display("FAIL gaps_latency: got first output cycle %0d, required %0d", sof_cyc, last_acc_cyc + 2);
      end
      compared = compared + 1;
      if (runs.size() != 1 || runs[0] != N) begin
         mismatched = mismatched + 1;
         $display("FAIL gaps_burst: got %0d bursts (first %0d), required 1 of %0d", runs.size(),
                  (runs.size() > 0) ? runs[0] : 0, N);
      end
   endtask

   task automatic test_restart();
      clear_stats();
      for (int k = 0; k < 7; k++) drive(1'b1, (k == 0), 16'(200 + k), 16'(300 + k));
      send_frame(400, 1'b0);
      repeat (24) @(negedge sys_clk);
      compared = compared + 1;
      if (err_cycles != 1 || err_cyc != first_acc_cyc) begin
         mismatched = mismatched + 1;
         $display("FAIL restart_err: got %0d high cycles at %0d, required 1 at %0d", err_cycles, err_cyc, first_acc_cyc);
      end
      compared = compared + 1;
      if (runs.size() != 1 || runs[0] != N) begin
         mismatched = mismatched + 1;
         $display("FAIL restart_burst: got %0d bursts (first %0d), required 1 of %0d", runs.size(),
                  (runs.size() > 0) ? runs[0] : 0, N);
      end
   endtask

   task automatic test_no_sof();
      do_reset();
      clear_stats();
      for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 16'(500 + k), 16'(600 + k));
      repeat (20) @(negedge sys_clk);
      compared = compared + 1;
      if (runs.size() != 0 || run_len != 0 || err_cycles != 0) begin
         mismatched = mismatched + 1;
         $display("FAIL no_sof_quiet: got %0d bursts, %0d err cycles, required 0 and 0", runs.size(), err_cycles);
      end
      send_frame(700, 1'b0);
      repeat (24) @(negedge sys_clk);
      compared = compared + 1;
      if (runs.size() != 1 || runs[0] != N || err_cycles != 0) begin
         mismatched = mismatched + 1;
         $display("FAIL no_sof_then_frame: got %0d bursts, %0d err cycles, required 1 and 0", runs.size(), err_cycles);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      clear_stats();
      send_frame(800, 1'b0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge sys_clk);
         if (dout_valid === 1'b1 && dout_idx === 4'd5) seen = 1'b1;
      end
      compared = compared + 1;
      if (!seen) begin
         mismatched = mismatched + 1;
         $display("FAIL reset_mid_reach_idx5: got no index 5 within 20 cycles, required it");
      end
      sys_rst = 1'b1;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      compared = compared + 1;
      if ({dout_valid, dout_sof, frame_err, dout_idx, dout_r, dout_i} !== 39'd0) begin
         mismatched = mismatched + 1;
         $display("FAIL reset_mid_outputs: got valid=%b idx=%0d r=%h i=%h, required all 0",
                  dout_valid, dout_idx, dout_r, dout_i);
      end
      exp_q.delete();
      repeat (20) @(negedge sys_clk);
      clear_stats();
      send_frame(900, 1'b0);
      repeat (24) @(negedge sys_clk);
      compared = compared + 1;
      if (runs.size() != 1 || runs[0] != N) begin
         mismatched = mismatched + 1;
         $display("FAIL reset_mid_recover: got %0d bursts (first %0d), required 1 of %0d", runs.size(),
                  (runs.size() > 0) ? runs[0] : 0, N);
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_gaps();
      test_restart();
      test_no_sof();
      test_reset_mid();
      compared = compared + 1;
      if (exp_q.size() != 0) begin
         mismatched = mismatched + 1;
         $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/r22sdf_bitrev_reorder.md
Name: r22sdf_bitrev_reorder

Overview:
- Output-side companion to the radix-2^2 SDF FFT core. It accepts the core's bit-reversed-order output stream and re-emits each frame in natural frequency order.
- Uses a ping-pong (two-bank) frame buffer: one bank is written at bit-reversed addresses while the other is read out sequentially.
- Sits directly after the FFT core, before downstream magnitude and spectral logic.

Parameters:
- data_resolution, 16, bit width of each real and imaginary sample.
- fft_length, 16, frame length N. Must be a power of 2 and at least 4. AW = log2(N).

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- din_valid  in  1  input sample is valid this cycle.
- din_sof  in  1  first sample of a frame; qualified by din_valid.
- din_r  in  data_resolution  FFT output, real part, bit-reversed order.
- din_i  in  data_resolution  FFT output, imaginary part, bit-reversed order.
- dout_valid  out  1  output sample is valid.
- dout_sof  out  1  high with natural index 0.
- dout_idx  out  AW  natural frequency bin index of the current output.
- dout_r  out  data_resolution  reordered real part.
- dout_i  out  data_resolution  reordered imaginary part.
- frame_err  out  1  one-cycle pulse: a partial frame was dropped.

Behaviour:
- Reset: wr_cnt=0, wr_bank=0, rd_active=0, rd_cnt=0, wr_synced=0. dout_valid, dout_sof, frame_err, dout_idx, dout_r and dout_i are all 0. RAM contents are don't-care.
- Write side:
  - A sample is accepted on a cycle with din_valid=1. Gaps (din_valid=0) are allowed anywhere and hold wr_cnt.
  - Until the first accepted din_sof, samples are ignored (wr_synced=0).
  - Write address = bitrev_AW(wr_cnt) in bank wr_bank. wr_cnt then increments modulo N.
  - Accepted din_sof forces that sample to wr_cnt=0.
  - If din_sof arrives while wr_cnt != 0: pulse frame_err for 1 cycle, discard the partial frame (no bank swap), and restart at 0 in the same bank.
  - When the sample with wr_cnt=N-1 is accepted (edge t):
    - toggle wr_bank;
    - set rd_active=1 on the read of the just-filled bank, with rd_cnt=0.
- Read side:
  - While rd_active, RAM read address = rd_cnt (natural order); rd_cnt increments every cycle with no gaps. At rd_cnt=N-1, rd_active clears.
  - RAM read is registered. Data, dout_idx, dout_valid and dout_sof are all registered to align.
  - Latency: last input accepted at edge t gives index 0 on the outputs after edge t+2. dout_valid then stays high for exactly N consecutive cycles.
  - dout_sof=1 only on the cycle with dout_idx=0.
  - When dout_valid=0, dout_r, dout_i and dout_idx hold their last value.
- Overrun: the next frame cannot complete within N cycles, so the read always finishes before the next swap. No backpressure is needed.
- Back-to-back frames: a completion swap in the same cycle as the last read of the previous frame is legal. The new read starts the next cycle, so output is continuous with no gap.
- Reset mid-operation: reset has priority over all events. The in-flight read aborts (dout_valid=0 the next cycle), the partial write is dropped, and the block waits for a fresh din_sof.
- No arithmetic is performed; data is passed bit-exact.

Decomposition:
- Shared package r22sdf_pkg: a clog2 constant function and a bitrev(value, width) function, both reused by the FFT core and its testbenches.
- One sub-module, r22sdf_reorder_ram:
  - simple dual-port RAM, depth 2N (address = {bank, addr}), width 2*data_resolution;
  - one write port, one registered read port;
  - inferable as block RAM.
- The top level holds the write and read counters, bank control and output registers.

Test Plan:
- N=16, din_sof on k=0, din_r=k and din_i=-k for k=0..15 continuous.
  - Expect dout_r = 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - Expect dout_idx = 0..15 and dout_sof only on the first output.
  - First output appears 2 cycles after k=15 is accepted.
- Three back-to-back frames with no gaps: dout_valid stays high for 48 consecutive cycles, and each frame reorders correctly.
- Same frame with din_valid toggling 1,0,1,0 (32 cycles): the output burst is still 16 contiguous cycles starting 2 cycles after the last accept.
- din_sof reasserted at k=7 of a frame:
  - frame_err pulses for 1 cycle;
  - no output for the dropped frame;
  - the following full frame outputs correctly.
- Samples with no leading din_sof: no output and no frame_err until the first din_sof.
- sys_rst asserted at output index 5: dout_valid=0 the next cycle with all outputs 0. A subsequent frame after din_sof outputs correctly.
